// File: rtl/pfw_pkg.sv
// pfw_pkg: shared header codes, action modes, multicast OUI and FSM states for the DMAC forwarder
package pfw_pkg;
  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_MID = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;
  localparam logic [1:0] MODE_UC = 2'b00;
  localparam logic [1:0] MODE_BC = 2'b10;
  localparam logic [1:0] MODE_MC = 2'b11;
  localparam logic [23:0] MCAST_OUI = 24'h01005e;
  typedef enum logic [1:0] {IDLE, LOOK, FWD, DROP} state_t;
endpackage

// File: rtl/pfw_cam.sv
// pfw_cam: DMAC table with config write port, parallel compare and lowest-index priority
//   clk, rst_n                    : clock, async active-low reset (clears every vld)
//   cfg_wr/addr/vld/mac/pmap      : entry write, takes effect at the next edge
//   key_mac                       : DMAC to look up
//   hit, pmap                     : lowest-index valid match and its egress bitmap
module pfw_cam #(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_PORT = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_wr,
  input  logic [$clog2(NUM_ENTRY > 1 ? NUM_ENTRY : 2)-1:0] cfg_addr,
  input  logic cfg_vld,
  input  logic [47:0] cfg_mac,
  input  logic [NUM_PORT-1:0] cfg_pmap,
  input  logic [47:0] key_mac,
  output logic hit,
  output logic [NUM_PORT-1:0] pmap
);
  logic [NUM_ENTRY-1:0] vld;
  logic [47:0] mac [NUM_ENTRY];
  logic [NUM_PORT-1:0] pm [NUM_ENTRY];
  logic we;
  assign we = cfg_wr && 32'(cfg_addr) < NUM_ENTRY;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        mac[i] <= '0;
        pm[i] <= '0;
      end
    end else if (we) begin
      vld[cfg_addr] <= cfg_vld;
      mac[cfg_addr] <= cfg_mac;
      pm[cfg_addr] <= cfg_pmap;
    end
  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    pmap = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--)
      if (vld[i] && mac[i] == key_mac) begin
        hit = 1'b1;
        pmap = pm[i];
      end
  end
endmodule

// File: rtl/pfw_tbl.sv
// pfw_tbl: per-packet DMAC forward/drop decision with 2-cycle pass-through and counters
//   in_data/_wr, in_valid/_wr, in_pkttype, in_key : packet stream, key/type sampled with head
//   in_reg_tap                                    : discard packets from TAP_PORT
//   cfg_*                                         : DMAC table write port
//   out_data/_wr, out_valid/_wr                   : stream delayed by 2 cycles
//   out_action/_wr                                : {mode, pkttype, pmap} with the head word
//   fwd_cnt, drop_cnt                             : wrapping statistics
//   PFW_FLOOD_ON_MISS_EN: flood (broadcast pmap) on a table miss instead of dropping
module pfw_tbl
  import pfw_pkg::*;
#(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_PORT = 6,
  parameter int TAP_PORT = 3,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [133:0] in_data,
  input  logic in_data_wr,
  input  logic in_valid,
  input  logic in_valid_wr,
  input  logic [2:0] in_pkttype,
  input  logic [53:0] in_key,
  input  logic in_reg_tap,
  input  logic cfg_wr,
  input  logic [$clog2(NUM_ENTRY > 1 ? NUM_ENTRY : 2)-1:0] cfg_addr,
  input  logic cfg_vld,
  input  logic [47:0] cfg_mac,
  input  logic [NUM_PORT-1:0] cfg_pmap,
  output logic [133:0] out_data,
  output logic out_data_wr,
  output logic out_valid,
  output logic out_valid_wr,
  output logic [4+NUM_PORT:0] out_action,
  output logic out_action_wr,
  output logic [CNT_W-1:0] fwd_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  state_t st, nxt;
  logic [133:0] s0;
  logic s0_vld;
  logic [53:0] key;
  logic [2:0] ptype;
  logic hit, bc, mc, tap, fwd, in_head, in_tail, s0_tail, emit, head_emit;
  logic [NUM_PORT-1:0] hit_pmap, bc_pmap, pmap;
  logic [1:0] mode;
  logic unused_valid;
  assign unused_valid = in_valid ^ in_valid_wr;
  pfw_cam #(.NUM_ENTRY(NUM_ENTRY), .NUM_PORT(NUM_PORT)) u_cam (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_vld(cfg_vld),
    .cfg_mac(cfg_mac), .cfg_pmap(cfg_pmap), .key_mac(key[47:0]), .hit(hit), .pmap(hit_pmap)
  );
  always_comb begin
    in_head = in_data_wr && in_data[133:132] == HDR_HEAD;
    in_tail = in_data_wr && in_data[133:132] == HDR_TAIL;
    s0_tail = s0_vld && s0[133:132] == HDR_TAIL;
    tap = in_reg_tap && key[53:48] == 6'(TAP_PORT);
    bc = &key[47:0];
    mc = key[47:24] == MCAST_OUI;
    // An ingress index past the port range shifts out entirely, leaving all ones.
    bc_pmap = ~(NUM_PORT'(1) << key[53:48]);
`ifdef PFW_FLOOD_ON_MISS_EN
    fwd = !tap;
`else
    fwd = !tap && (bc || hit);
`endif
    mode = (bc || !hit) ? MODE_BC : mc ? MODE_MC : MODE_UC;
    pmap = (bc || !hit) ? bc_pmap : hit_pmap;
    head_emit = st == LOOK && fwd;
    emit = head_emit || (st == FWD && s0_vld);
  end
  // Leaving FWD while the tail sits in s0 lets a head arriving now start LOOK with no bubble.
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE: nxt = in_head ? LOOK : IDLE;
      LOOK: nxt = fwd ? FWD : in_tail ? IDLE : DROP;
      FWD:  nxt = s0_tail ? (in_head ? LOOK : IDLE) : FWD;
      DROP: nxt = in_tail ? IDLE : DROP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0 <= '0;
      s0_vld <= 1'b0;
      key <= '0;
      ptype <= '0;
      out_data <= '0;
      out_data_wr <= 1'b0;
      out_valid <= 1'b0;
      out_valid_wr <= 1'b0;
      out_action <= '0;
      out_action_wr <= 1'b0;
      fwd_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      s0 <= in_data;
      s0_vld <= in_data_wr && (nxt == LOOK || nxt == FWD);
      if (nxt == LOOK) begin
        key <= in_key;
        ptype <= in_pkttype;
      end
      out_data <= emit ? s0 : '0;
      out_data_wr <= emit;
      out_valid <= emit && s0_tail;
      out_valid_wr <= emit && s0_tail;
      out_action <= head_emit ? {mode, ptype, pmap} : '0;
      out_action_wr <= head_emit;
      fwd_cnt <= fwd_cnt + CNT_W'(head_emit);
      drop_cnt <= drop_cnt + CNT_W'(st == LOOK && !fwd);
    end
endmodule

// File: doc/pfw_tbl.md
Name: pfw_tbl

Overview:
- Parametrised successor to the fixed 12-entry forwarder; sits between the key extractor and the action/queue stage (pac).
- Per packet: decides discard or forward and builds an egress port bitmap from a software-writable DMAC table of NUM_ENTRY entries.
- Passes the packet through with a fixed 2-cycle latency. Adds per-ingress flood masking, lowest-index priority, and forward/drop counters.

Parameters:
- NUM_ENTRY, 16, number of DMAC table entries (1..64)
- NUM_PORT, 6, egress ports; width of the bitmap in the action
- TAP_PORT, 3, ingress port discarded when in_reg_tap=1
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  134  packet word; [133:132]: 01 head, 11 middle, 10 tail
- in_data_wr  in  1  in_data valid
- in_valid  in  1  end-of-packet status
- in_valid_wr  in  1  in_valid strobe
- in_pkttype  in  3  packet type; sampled with the head
- in_key  in  54  {inport[5:0], dmac[47:0]}; sampled with the head
- in_reg_tap  in  1  tap-port discard enable
- cfg_wr  in  1  table write strobe
- cfg_addr  in  $clog2(NUM_ENTRY)  entry index
- cfg_vld  in  1  entry valid bit
- cfg_mac  in  48  entry MAC
- cfg_pmap  in  NUM_PORT  entry egress bitmap
- out_data  out  134  delayed packet word
- out_data_wr  out  1  out_data valid
- out_valid  out  1  end-of-packet status
- out_valid_wr  out  1  out_valid strobe
- out_action  out  5+NUM_PORT  {mode[1:0], pkttype[2:0], pmap}
- out_action_wr  out  1  action strobe, coincident with head out
- fwd_cnt  out  CNT_W  packets forwarded
- drop_cnt  out  CNT_W  packets dropped

Behaviour:
- Reset: all outputs 0, counters 0, every table entry vld=0, FSM in IDLE.
- Reset asserted mid-packet aborts the packet; no further output words for it.
- FSM states: IDLE, LOOK, FWD, DROP.
  - IDLE: a non-head word is ignored. A head with data_wr=1 goes to LOOK, latching key, pkttype and word (stage0).
  - LOOK (1 cycle): registered match vector. Decision, in priority order:
    1. in_reg_tap=1 and inport==TAP_PORT: DROP.
    2. dmac=all-ones: mode 10, pmap all ones except bit inport (all ones if inport>=NUM_PORT).
    3. dmac[47:24]=01005e: mode 11, pmap of the matching entry.
    4. Otherwise: mode 00, pmap of the matching entry.
    - Multiple matches: lowest index wins. No match for rules 3 or 4: DROP.
  - FWD: each input word appears on out_data exactly 2 cycles later. The head word carries out_action_wr=1 for 1 cycle. The tail word carries out_valid=1, out_valid_wr=1.
  - FWD exit: on the tail, a head arriving in the same or next cycle goes directly to LOOK (back-to-back, no bubble); otherwise IDLE.
  - DROP: no output; returns to IDLE on input tail (head+tail in one word returns immediately).
- in_valid/in_valid_wr are accepted but regenerated on the tail output.
- Counters: fwd_cnt +1 on each action_wr; drop_cnt +1 on each DROP decision. Both wrap at 2^CNT_W.
- Table:
  - cfg_wr updates the entry at the next edge.
  - A lookup in the same cycle as a write to that entry uses the old value.
  - cfg_addr>=NUM_ENTRY is ignored.
  - Entries with vld=0 never match.
- pmap=0 on a hit is forwarded with an empty bitmap; this is not a drop.

Optional Feature:
- Macro: PFW_FLOOD_ON_MISS_EN.
- Defined: a unicast/multicast miss forwards with mode 10 and the broadcast pmap (ingress excluded), counted in fwd_cnt.
- Undefined: a miss is dropped and counted in drop_cnt.

Decomposition:
- Shared package pfw_pkg:
  - header codes HDR_HEAD/HDR_MID/HDR_TAIL
  - mode encodings MODE_UC=00, MODE_BC=10, MODE_MC=11
  - MCAST_OUI=24'h01005e
  - FSM state typedef
- Sub-module pfw_cam: table registers, config write port, parallel compare, lowest-index priority encoder; outputs hit and pmap.

Test Plan:
1. Entry 2 = {vld=1, MAC 00:11:22:33:44:55, pmap 000100}; 3-word unicast to that MAC, inport 0 -> head out 2 cycles later, action={00,type,000100}, out_valid_wr on tail, fwd_cnt=1.
2. Broadcast key, inport 1, NUM_PORT=6 -> action pmap 111101, mode 10.
3. Unknown DMAC -> no output, drop_cnt=1. With PFW_FLOOD_ON_MISS_EN: forwarded, mode 10.
4. in_reg_tap=1, inport 3 -> packet dropped even when the DMAC is a table hit.
5. Entries 1 and 5 both hold the same MAC (pmaps 000001/100000) -> pmap 000001. Two back-to-back packets -> no bubble between tail and head on out_data.
6. cfg_wr invalidating entry 2 in the same cycle as LOOK -> old pmap used; next packet dropped. rst_n low mid-packet -> outputs 0, counters 0, table cleared.
